// File: rtl/cga_pixel_serializer.sv
// rtl/cga_pixel_serializer.sv - CGA/Tandy word FIFO, bpp shifter, palette and border/underrun output stage
module cga_pixel_serializer #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        bpp_sel,
  input  logic [1:0]        pix_rep,
  input  logic              display_enable,
  input  logic [3:0]        border_col,
  input  logic              pal_we,
  input  logic [3:0]        pal_addr,
  input  logic [3:0]        pal_data,
  input  logic              underrun_clr,
  output logic [3:0]        video,
  output logic              pix_strobe,
  output logic              underrun
);

  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = AW + 1;
  localparam int PL_W = $clog2(DATA_W + 1);

  localparam logic [PL_W-1:0] NPIX_1 = PL_W'(DATA_W);
  localparam logic [PL_W-1:0] NPIX_2 = PL_W'(DATA_W / 2);
  localparam logic [PL_W-1:0] NPIX_4 = PL_W'(DATA_W / 4);

  // Reject word widths that do not split into whole 4bpp pixels, and odd FIFO depths
  if ((DATA_W % 4) != 0 || DATA_W < 8) begin : g_bad_data_w
    $error("DATA_W must be a multiple of 4 and at least 8");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_next;
  logic              push;
  logic              pop;
  logic              fifo_empty;

  // Shifter state
  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_shifted;
  logic [1:0]        bpp_q;
  logic [PL_W-1:0]   pix_left;
  logic [PL_W-1:0]   word_pixels;
  logic [1:0]        rep_q;
  logic [1:0]        rep_cnt;
  logic [3:0]        pix_idx;

  // Control decoded from shifter state
  logic active;
  logic last_rep;
  logic need_word;
  logic load;
  logic starve;
  logic advance;

  // Palette
  logic [3:0] pal [16];

  assign fifo_empty = (count == '0);
  assign push       = in_valid && in_ready;
  assign pop        = load;
  assign count_next = count + CW'(push) - CW'(pop);

  // Push data into the word FIFO; contents need no reset because count gates reads
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // FIFO pointers, occupancy and registered ready
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count_next;
      in_ready <= (count_next != CW'(FIFO_DEPTH));
    end
  end

  // Current pixel index and the shift register after dropping that pixel
  always_comb begin
    pix_idx       = shreg[DATA_W-1 -: 4];
    shreg_shifted = shreg << 4;
    case (bpp_q)
      2'b00: begin
        pix_idx       = {3'b000, shreg[DATA_W-1]};
        shreg_shifted = shreg << 1;
      end
      2'b01: begin
        pix_idx       = {2'b00, shreg[DATA_W-1 -: 2]};
        shreg_shifted = shreg << 2;
      end
      default: begin
        pix_idx       = shreg[DATA_W-1 -: 4];
        shreg_shifted = shreg << 4;
      end
    endcase
  end

  // Pixel count of a word at the bpp presented on the load edge
  always_comb begin
    case (bpp_sel)
      2'b00:   word_pixels = NPIX_1;
      2'b01:   word_pixels = NPIX_2;
      default: word_pixels = NPIX_4;
    endcase
  end

  // Shifter next state and load/advance/starve decisions
  always_comb begin
    active     = (state != S_IDLE);
    last_rep   = (rep_cnt == rep_q);
    need_word  = !active || (last_rep && pix_left == PL_W'(1));
    load       = display_enable && need_word && !fifo_empty;
    starve     = display_enable && need_word && fifo_empty;
    advance    = display_enable && active && last_rep && (pix_left != PL_W'(1));
    state_next = state;
    if (!display_enable) begin
      state_next = S_IDLE;
    end else if (load) begin
      state_next = S_LOAD;
    end else if (starve) begin
      state_next = S_IDLE;
    end else if (state == S_LOAD) begin
      state_next = S_SHIFT;
    end
  end

  // Shifter state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Shift register, per-word bpp and per-pixel repeat counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg    <= '0;
      bpp_q    <= 2'b00;
      pix_left <= '0;
      rep_q    <= 2'b00;
      rep_cnt  <= 2'b00;
    end else if (load) begin
      shreg    <= mem[rd_ptr];
      bpp_q    <= bpp_sel;
      pix_left <= word_pixels;
      rep_q    <= pix_rep;
      rep_cnt  <= 2'b00;
    end else if (advance) begin
      shreg    <= shreg_shifted;
      pix_left <= pix_left - PL_W'(1);
      rep_q    <= pix_rep;
      rep_cnt  <= 2'b00;
    end else if (display_enable && active && !starve) begin
      rep_cnt  <= rep_cnt + 2'd1;
    end else if (!display_enable || starve) begin
      pix_left <= '0;
      rep_cnt  <= 2'b00;
    end
  end

  // Palette RAM; reads on the same edge see the value before this write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        pal[i] <= 4'(i);
      end
    end else if (pal_we) begin
      pal[pal_addr] <= pal_data;
    end
  end

  // Output stage: border outside the window, palette colour inside
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      video      <= 4'h0;
      pix_strobe <= 1'b0;
    end else if (!display_enable) begin
      video      <= border_col;
      pix_strobe <= 1'b0;
    end else if (active) begin
      video      <= pal[pix_idx];
      pix_strobe <= (rep_cnt == 2'b00);
    end else begin
      video      <= pal[0];
      pix_strobe <= 1'b0;
    end
  end

  // Sticky underrun flag; a set wins over a simultaneous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underrun <= 1'b0;
    end else if (starve) begin
      underrun <= 1'b1;
    end else if (underrun_clr) begin
      underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cga_pixel_serializer.sv
// tb/tb_cga_pixel_serializer.sv - directed table-driven bench for cga_pixel_serializer
module tb_cga_pixel_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  bpp_sel;
  logic [1:0]  pix_rep;
  logic        display_enable;
  logic [3:0]  border_col;
  logic        pal_we;
  logic [3:0]  pal_addr;
  logic [3:0]  pal_data;
  logic        underrun_clr;
  logic [3:0]  video;
  logic        pix_strobe;
  logic        underrun;

  int checks   = 0;
  int failures = 0;

  cga_pixel_serializer #(.DATA_W(16), .FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .bpp_sel        (bpp_sel),
    .pix_rep        (pix_rep),
    .display_enable (display_enable),
    .border_col     (border_col),
    .pal_we         (pal_we),
    .pal_addr       (pal_addr),
    .pal_data       (pal_data),
    .underrun_clr   (underrun_clr),
    .video          (video),
    .pix_strobe     (pix_strobe),
    .underrun       (underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  bpp;
    logic [1:0]  rep;
    logic [15:0] w0;
    logic [15:0] w1;
    int          nwords;
    int          ncyc;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic push_word(input logic [15:0] w);
    in_valid = 1'b1;
    in_data  = w;
    step();
    in_valid = 1'b0;
  endtask

  task automatic clear_underrun();
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
  endtask

  task automatic pal_write(input logic [3:0] a, input logic [3:0] d);
    pal_we   = 1'b1;
    pal_addr = a;
    pal_data = d;
    step();
    pal_we   = 1'b0;
  endtask

  // Push words with the window closed, open it, then compare every output cycle
  task automatic run_vector(input int idx);
    vec_t v;
    logic [3:0] e;
    v = vecs[idx];
    display_enable = 1'b0;
    clear_underrun();
    bpp_sel = v.bpp;
    pix_rep = v.rep;
    push_word(v.w0);
    if (v.nwords > 1) push_word(v.w1);
    display_enable = 1'b1;
    step();
    step();
    for (int k = 0; k < v.ncyc; k++) begin
      e = v.exp[63 - 4*k -: 4];
      check($sformatf("v%0d video[%0d]", idx, k), {12'h0, video}, {12'h0, e});
      check($sformatf("v%0d strobe[%0d]", idx, k), {15'h0, pix_strobe},
            {15'h0, ((k % (int'(v.rep) + 1)) == 0)});
      step();
    end
    check($sformatf("v%0d underrun_at_end", idx), {15'h0, underrun}, 16'h1);
    display_enable = 1'b0;
    step();
    check($sformatf("v%0d border", idx), {12'h0, video}, {12'h0, border_col});
  endtask

  initial begin
    vecs[0] = '{bpp: 2'b00, rep: 2'd0, w0: 16'hA5A5, w1: 16'h0000, nwords: 1, ncyc: 16, exp: 64'h1010_0101_1010_0101};
    vecs[1] = '{bpp: 2'b01, rep: 2'd0, w0: 16'h1B1B, w1: 16'hE4E4, nwords: 2, ncyc: 16, exp: 64'h0123_0123_3210_3210};
    vecs[2] = '{bpp: 2'b10, rep: 2'd1, w0: 16'h3C5A, w1: 16'h0000, nwords: 1, ncyc: 8,  exp: 64'h33CC_55AA_0000_0000};
    vecs[3] = '{bpp: 2'b11, rep: 2'd0, w0: 16'h1234, w1: 16'h5678, nwords: 2, ncyc: 8,  exp: 64'h1234_5678_0000_0000};
    vecs[4] = '{bpp: 2'b01, rep: 2'd1, w0: 16'h6C00, w1: 16'h0000, nwords: 1, ncyc: 16, exp: 64'h1122_3300_0000_0000};
    vecs[5] = '{bpp: 2'b01, rep: 2'd0, w0: 16'hFFFF, w1: 16'h0000, nwords: 1, ncyc: 8,  exp: 64'hEEEE_EEEE_0000_0000};

    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    bpp_sel = 2'b00;
    pix_rep = 2'd0;
    display_enable = 1'b0;
    border_col = 4'h9;
    pal_we = 1'b0;
    pal_addr = '0;
    pal_data = '0;
    underrun_clr = 1'b0;

    // Reset state
    step();
    step();
    check("rst video", {12'h0, video}, 16'h0);
    check("rst in_ready", {15'h0, in_ready}, 16'h0);
    check("rst strobe", {15'h0, pix_strobe}, 16'h0);
    check("rst underrun", {15'h0, underrun}, 16'h0);
    #2 reset = 1'b0;
    check("in_ready before edge", {15'h0, in_ready}, 16'h0);
    step();
    check("in_ready after release", {15'h0, in_ready}, 16'h1);

    // Table-driven pixel streams with the identity palette
    for (int i = 0; i < 5; i++) run_vector(i);

    // Palette rewrite then stream through it
    pal_write(4'd3, 4'hE);
    run_vector(5);

    // Same-edge write and read of pal[3]: first pixel old, next new
    display_enable = 1'b0;
    clear_underrun();
    bpp_sel = 2'b01;
    pix_rep = 2'd0;
    push_word(16'hFFFF);
    display_enable = 1'b1;
    step();
    pal_we = 1'b1;
    pal_addr = 4'd3;
    pal_data = 4'h5;
    step();
    pal_we = 1'b0;
    check("pal same-cycle old", {12'h0, video}, 16'hE);
    step();
    check("pal next-cycle new", {12'h0, video}, 16'h5);
    display_enable = 1'b0;
    step();
    pal_write(4'd3, 4'd3);

    // Underrun with empty FIFO, set beats clear, border leaves flag alone
    clear_underrun();
    check("underrun cleared", {15'h0, underrun}, 16'h0);
    display_enable = 1'b1;
    step();
    check("starve video pal0", {12'h0, video}, 16'h0);
    check("starve underrun", {15'h0, underrun}, 16'h1);
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    check("set beats clear", {15'h0, underrun}, 16'h1);
    display_enable = 1'b0;
    step();
    check("border video", {12'h0, video}, 16'h9);
    check("border keeps underrun", {15'h0, underrun}, 16'h1);
    step();
    check("border still held", {15'h0, underrun}, 16'h1);
    clear_underrun();
    check("underrun clr", {15'h0, underrun}, 16'h0);

    // Fill FIFO, start a word, reset mid-word
    bpp_sel = 2'b10;
    pix_rep = 2'd0;
    push_word(16'h1111);
    push_word(16'h2222);
    push_word(16'h3333);
    check("in_ready 3 words", {15'h0, in_ready}, 16'h1);
    push_word(16'h4444);
    check("in_ready full", {15'h0, in_ready}, 16'h0);
    display_enable = 1'b1;
    step();
    step();
    check("pre-reset pixel", {12'h0, video}, 16'h1);
    #2 reset = 1'b1;
    #1;
    check("async rst video", {12'h0, video}, 16'h0);
    check("async rst in_ready", {15'h0, in_ready}, 16'h0);
    display_enable = 1'b0;
    step();
    #2 reset = 1'b0;
    step();
    check("in_ready after 2nd release", {15'h0, in_ready}, 16'h1);
    display_enable = 1'b1;
    step();
    check("no stale pixel", {12'h0, video}, 16'h0);
    check("empty after reset underrun", {15'h0, underrun}, 16'h1);
    step();
    check("no stale pixel 2", {12'h0, video}, 16'h0);
    display_enable = 1'b0;
    step();

    // Fresh word after reset comes out intact
    vecs[0] = '{bpp: 2'b10, rep: 2'd0, w0: 16'h9876, w1: 16'h0000, nwords: 1, ncyc: 4, exp: 64'h9876_0000_0000_0000};
    run_vector(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
